// File: rtl/thumb_pkg.sv
// Shared definitions for the thumbnail read arbiter: thumbnail geometry,
// coordinate widths, pointer width and the arbiter FSM state encoding.
package thumb_pkg;

  localparam int THUMB_W = 40;
  localparam int THUMB_H = 30;
  localparam int X_W     = 6;
  localparam int Y_W     = 5;
  localparam int PIX_W   = 8;
  localparam int PTR_W   = 2;

  typedef enum logic [0:0] {
    ST_ARB    = 1'b0,
    ST_LOCKED = 1'b1
  } arb_state_t;

  // True when (x, y) addresses a pixel inside the thumbnail.
  function automatic logic in_range(input logic [X_W-1:0] x, input logic [Y_W-1:0] y);
    return (int'(x) < THUMB_W) && (int'(y) < THUMB_H);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: returns a one-hot pick of the first
// asserted request found when searching upward from ptr, wrapping at NUM_REQ.
module rr_pick
  import thumb_pkg::*;
#(
  parameter int NUM_REQ = 3
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] pick
);

  int   idx;
  logic found;

  // Walk the requesters starting at ptr and keep only the first hit.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && req[idx]) begin
        pick[idx] = 1'b1;
        found     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/thumb_read_arb.sv
// Round-robin read arbiter in front of the thumbnail buffer read port.
// Grants one requester per cycle, registers its address toward the buffer and
// returns the pixel two cycles after the grant through a small tag pipeline.
// Optional burst locking is enabled by defining THUMB_ARB_LOCK_EN.
module thumb_read_arb
  import thumb_pkg::*;
#(
  parameter int NUM_REQ  = 3,
  parameter int MAX_LOCK = 40
) (
  input  logic                   read_clock,
  input  logic                   resetn,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [X_W*NUM_REQ-1:0] req_x,
  input  logic [Y_W*NUM_REQ-1:0] req_y,
  input  logic [NUM_REQ-1:0]     lock,
  output logic [NUM_REQ-1:0]     gnt,
  output logic [NUM_REQ-1:0]     rsp_valid,
  output logic [PIX_W-1:0]       rsp_data,
  output logic                   rsp_err,
  output logic [X_W-1:0]         read_x,
  output logic [Y_W-1:0]         read_y,
  input  logic [PIX_W-1:0]       read_q
);

  logic [PTR_W-1:0]   ptr, ptr_nxt;
  logic [NUM_REQ-1:0] pick, gnt_raw;
  logic [PTR_W-1:0]   gnt_idx;
  logic               gnt_any;
  logic [X_W-1:0]     sel_x;
  logic [Y_W-1:0]     sel_y;
  logic               sel_ok;

  logic               vld_p0, err_p0, vld_p1, err_p1;
  logic [PTR_W-1:0]   idx_p0, idx_p1;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (int'(p) == NUM_REQ - 1) ? '0 : p + 1'b1;
  endfunction

  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req  (req),
    .ptr  (ptr),
    .pick (pick)
  );

  // Grant is held off while reset is asserted.
  assign gnt     = gnt_raw & {NUM_REQ{resetn}};
  assign gnt_any = |gnt;

  // Encode the one-hot grant and select the granted requester's address.
  always_comb begin
    gnt_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (gnt[k]) gnt_idx = PTR_W'(k);
    end
    sel_x  = req_x[int'(gnt_idx)*X_W +: X_W];
    sel_y  = req_y[int'(gnt_idx)*Y_W +: Y_W];
    sel_ok = in_range(sel_x, sel_y);
  end

`ifdef THUMB_ARB_LOCK_EN
  localparam logic [5:0] LOCK_LIM = 6'(MAX_LOCK);

  arb_state_t       state, state_nxt;
  logic [PTR_W-1:0] owner, owner_nxt;
  logic [5:0]       lock_cnt, lock_cnt_nxt;

  // Lock FSM: grant selection, lock entry/exit and pointer update.
  always_comb begin
    gnt_raw      = pick;
    state_nxt    = state;
    owner_nxt    = owner;
    lock_cnt_nxt = lock_cnt;
    ptr_nxt      = ptr;
    case (state)
      ST_ARB: begin
        if (gnt_any) begin
          ptr_nxt = ptr_inc(gnt_idx);
          if (lock[gnt_idx]) begin
            state_nxt    = ST_LOCKED;
            owner_nxt    = gnt_idx;
            lock_cnt_nxt = 6'd1;
          end
        end
      end
      ST_LOCKED: begin
        gnt_raw        = '0;
        gnt_raw[owner] = req[owner];
        if (gnt_any) lock_cnt_nxt = lock_cnt + 6'd1;
        if (!lock[owner] || (gnt_any && (lock_cnt_nxt >= LOCK_LIM))) begin
          state_nxt    = ST_ARB;
          ptr_nxt      = ptr_inc(owner);
          lock_cnt_nxt = '0;
        end
      end
      default: begin
        state_nxt = ST_ARB;
      end
    endcase
  end

  // Lock FSM and priority pointer state.
  always_ff @(posedge read_clock or negedge resetn) begin
    if (!resetn) begin
      state    <= ST_ARB;
      owner    <= '0;
      lock_cnt <= '0;
      ptr      <= '0;
    end else begin
      state    <= state_nxt;
      owner    <= owner_nxt;
      lock_cnt <= lock_cnt_nxt;
      ptr      <= ptr_nxt;
    end
  end
`else
  logic unused_lock;
  assign unused_lock = ^lock;

  // Pure round-robin: grant the pick and advance past the winner.
  always_comb begin
    gnt_raw = pick;
    ptr_nxt = gnt_any ? ptr_inc(gnt_idx) : ptr;
  end

  // Priority pointer state.
  always_ff @(posedge read_clock or negedge resetn) begin
    if (!resetn) ptr <= '0;
    else         ptr <= ptr_nxt;
  end
`endif

  // Address register toward the buffer and the two-stage response tag.
  always_ff @(posedge read_clock or negedge resetn) begin
    if (!resetn) begin
      read_x <= '0;
      read_y <= '0;
      vld_p0 <= 1'b0;
      idx_p0 <= '0;
      err_p0 <= 1'b0;
      vld_p1 <= 1'b0;
      idx_p1 <= '0;
      err_p1 <= 1'b0;
    end else begin
      // p0: grant accepted, address launched to the buffer
      vld_p0 <= gnt_any;
      if (gnt_any) begin
        idx_p0 <= gnt_idx;
        err_p0 <= !sel_ok;
        if (sel_ok) begin
          read_x <= sel_x;
          read_y <= sel_y;
        end
      end
      // p1: buffer data lines up with this tag
      vld_p1 <= vld_p0;
      idx_p1 <= idx_p0;
      err_p1 <= err_p0;
    end
  end

  // Response strobe and data; everything is zero when no response is due.
  always_comb begin
    rsp_valid = '0;
    rsp_data  = '0;
    rsp_err   = 1'b0;
    if (vld_p1) begin
      rsp_valid[idx_p1] = 1'b1;
      rsp_err           = err_p1;
      rsp_data          = err_p1 ? '0 : read_q;
    end
  end

endmodule

// File: tb/tb_thumb_read_arb.sv
// Directed bench for thumb_read_arb (NUM_REQ=3). Lock checks follow
// THUMB_ARB_LOCK_EN when it is defined for the build.
module tb_thumb_read_arb;

  logic        clk = 1'b0;
  logic        resetn;
  logic [2:0]  req, lock, gnt, rsp_valid;
  logic [17:0] req_x;
  logic [14:0] req_y;
  logic [7:0]  rsp_data, read_q;
  logic        rsp_err;
  logic [5:0]  read_x;
  logic [4:0]  read_y;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  thumb_read_arb #(.NUM_REQ(3), .MAX_LOCK(40)) dut (
    .read_clock (clk),
    .resetn     (resetn),
    .req        (req),
    .req_x      (req_x),
    .req_y      (req_y),
    .lock       (lock),
    .gnt        (gnt),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data),
    .rsp_err    (rsp_err),
    .read_x     (read_x),
    .read_y     (read_y),
    .read_q     (read_q)
  );

  function automatic logic [7:0] pix(input logic [5:0] x, input logic [4:0] y);
    return 8'(int'(x) * 8 + int'(y)) ^ 8'h8A;
  endfunction

  // Buffer model: registered read, one cycle after the address.
  always @(posedge clk) read_q <= pix(read_x, read_y);

  typedef struct {
    logic [2:0] req;
    logic       bad0;
    logic       bad2;
    logic [2:0] gnt;
    logic [2:0] rv;
    logic [7:0] dat;
    logic       err;
    logic [5:0] rx;
    logic [4:0] ry;
  } vec_t;

  vec_t tbl[23];

  function automatic vec_t mk(input logic [2:0] r, input logic b0, input logic b2,
                              input logic [2:0] g, input logic [2:0] v,
                              input logic [7:0] d, input logic e,
                              input logic [5:0] x, input logic [4:0] y);
    vec_t t;
    t.req = r; t.bad0 = b0; t.bad2 = b2; t.gnt = g; t.rv = v;
    t.dat = d; t.err = e; t.rx = x; t.ry = y;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Requester coordinates: r0=(1,2) or (40,0), r1=(5,7), r2=(3,4) or (0,30).
  task automatic drive(input logic [2:0] r, input logic b0, input logic b2, input logic [2:0] lk);
    logic [5:0] x0, x2;
    logic [4:0] y0, y2;
    x0 = b0 ? 6'd40 : 6'd1;
    y0 = b0 ? 5'd0  : 5'd2;
    x2 = b2 ? 6'd0  : 6'd3;
    y2 = b2 ? 5'd30 : 5'd4;
    req   = r;
    lock  = lk;
    req_x = {x2, 6'd5, x0};
    req_y = {y2, 5'd7, y0};
  endtask

  initial begin
    logic [7:0] p0, p1, p2;
    p0 = pix(6'd1, 5'd2);
    p1 = pix(6'd5, 5'd7);
    p2 = pix(6'd3, 5'd4);

    //                 req     b0 b2 gnt     rv      dat    err rx  ry
    tbl[0]  = mk(3'b111, 0, 0, 3'b001, 3'b000, 8'h00, 0, 0, 0);
    tbl[1]  = mk(3'b111, 0, 0, 3'b010, 3'b000, 8'h00, 0, 1, 2);
    tbl[2]  = mk(3'b111, 0, 0, 3'b100, 3'b001, p0,    0, 5, 7);
    tbl[3]  = mk(3'b111, 0, 0, 3'b001, 3'b010, p1,    0, 3, 4);
    tbl[4]  = mk(3'b111, 0, 0, 3'b010, 3'b100, p2,    0, 1, 2);
    tbl[5]  = mk(3'b111, 0, 0, 3'b100, 3'b001, p0,    0, 5, 7);
    tbl[6]  = mk(3'b000, 0, 0, 3'b000, 3'b010, p1,    0, 3, 4);
    tbl[7]  = mk(3'b000, 0, 0, 3'b000, 3'b100, p2,    0, 3, 4);
    tbl[8]  = mk(3'b000, 0, 0, 3'b000, 3'b000, 8'h00, 0, 3, 4);
    tbl[9]  = mk(3'b010, 0, 0, 3'b010, 3'b000, 8'h00, 0, 3, 4);
    tbl[10] = mk(3'b000, 0, 0, 3'b000, 3'b000, 8'h00, 0, 5, 7);
    tbl[11] = mk(3'b000, 0, 0, 3'b000, 3'b010, 8'hA5, 0, 5, 7);
    tbl[12] = mk(3'b001, 1, 0, 3'b001, 3'b000, 8'h00, 0, 5, 7);
    tbl[13] = mk(3'b000, 1, 0, 3'b000, 3'b000, 8'h00, 0, 5, 7);
    tbl[14] = mk(3'b000, 1, 0, 3'b000, 3'b001, 8'h00, 1, 5, 7);
    tbl[15] = mk(3'b100, 0, 1, 3'b100, 3'b000, 8'h00, 0, 5, 7);
    tbl[16] = mk(3'b000, 0, 1, 3'b000, 3'b000, 8'h00, 0, 5, 7);
    tbl[17] = mk(3'b000, 0, 1, 3'b000, 3'b100, 8'h00, 1, 5, 7);
    tbl[18] = mk(3'b110, 0, 1, 3'b010, 3'b000, 8'h00, 0, 5, 7);
    tbl[19] = mk(3'b100, 0, 1, 3'b100, 3'b000, 8'h00, 0, 5, 7);
    tbl[20] = mk(3'b000, 0, 1, 3'b000, 3'b010, 8'hA5, 0, 5, 7);
    tbl[21] = mk(3'b000, 0, 1, 3'b000, 3'b100, 8'h00, 1, 5, 7);
    tbl[22] = mk(3'b000, 0, 1, 3'b000, 3'b000, 8'h00, 0, 5, 7);

    // Reset with requests pending: nothing may be granted or returned.
    resetn = 1'b0;
    drive(3'b111, 0, 0, 3'b000);
    #2;
    chk("reset_gnt",   32'(gnt), 32'h0);
    chk("reset_rv",    32'(rsp_valid), 32'h0);
    chk("reset_data",  32'(rsp_data), 32'h0);
    chk("reset_err",   32'(rsp_err), 32'h0);
    chk("reset_rx",    32'(read_x), 32'h0);
    chk("reset_ry",    32'(read_y), 32'h0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;

    // Table: one row per cycle, inputs at negedge, outputs checked 2ns later.
    for (int i = 0; i < 23; i++) begin
      if (i > 0) @(negedge clk);
      drive(tbl[i].req, tbl[i].bad0, tbl[i].bad2, 3'b000);
      #2;
      chk($sformatf("gnt[%0d]", i),  32'(gnt),       32'(tbl[i].gnt));
      chk($sformatf("rv[%0d]", i),   32'(rsp_valid), 32'(tbl[i].rv));
      chk($sformatf("data[%0d]", i), 32'(rsp_data),  32'(tbl[i].dat));
      chk($sformatf("err[%0d]", i),  32'(rsp_err),   32'(tbl[i].err));
      chk($sformatf("rx[%0d]", i),   32'(read_x),    32'(tbl[i].rx));
      chk($sformatf("ry[%0d]", i),   32'(read_y),    32'(tbl[i].ry));
    end

    // Point the pointer at requester 2 by granting requester 1 once.
    @(negedge clk);
    drive(3'b010, 0, 0, 3'b000);
    #2;
    chk("pre_lock_gnt", 32'(gnt), 32'h2);

`ifdef THUMB_ARB_LOCK_EN
    // Locked burst: 40 grants to requester 2, then requester 0.
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      drive(3'b101, 0, 0, 3'b100);
      #2;
      chk($sformatf("lock_gnt[%0d]", k), 32'(gnt), 32'h4);
    end
    @(negedge clk);
    drive(3'b101, 0, 0, 3'b100);
    #2;
    chk("lock_release_gnt", 32'(gnt), 32'h1);
    // Owner drops req while locked: no grant, lock kept.
    @(negedge clk);
    drive(3'b100, 0, 0, 3'b100);
    #2;
    chk("lock2_first", 32'(gnt), 32'h4);
    @(negedge clk);
    drive(3'b001, 0, 0, 3'b100);
    #2;
    chk("lock2_owner_idle", 32'(gnt), 32'h0);
    @(negedge clk);
    drive(3'b101, 0, 0, 3'b100);
    #2;
    chk("lock2_owner_back", 32'(gnt), 32'h4);
    @(negedge clk);
    drive(3'b001, 0, 0, 3'b000);
    #2;
    chk("lock2_drop", 32'(gnt), 32'h0);
    @(negedge clk);
    drive(3'b001, 0, 0, 3'b000);
    #2;
    chk("lock2_after", 32'(gnt), 32'h1);
`else
    // Lock ignored: requesters 2 and 0 alternate.
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      drive(3'b101, 0, 0, 3'b100);
      #2;
      chk($sformatf("nolock_gnt[%0d]", k), 32'(gnt), (k % 2 == 0) ? 32'h4 : 32'h1);
    end
`endif

    // Reset one cycle after a grant: in-flight responses are dropped.
    @(negedge clk);
    drive(3'b111, 0, 0, 3'b000);
    #2;
    chk("mid_gnt_any", 32'(gnt != 3'b000), 32'h1);
    @(negedge clk);
    resetn = 1'b0;
    #2;
    chk("mid_rst_gnt",  32'(gnt), 32'h0);
    chk("mid_rst_rv",   32'(rsp_valid), 32'h0);
    chk("mid_rst_data", 32'(rsp_data), 32'h0);
    chk("mid_rst_err",  32'(rsp_err), 32'h0);
    chk("mid_rst_rx",   32'(read_x), 32'h0);
    chk("mid_rst_ry",   32'(read_y), 32'h0);
    @(negedge clk);
    resetn = 1'b1;
    drive(3'b000, 0, 0, 3'b000);
    for (int k = 0; k < 3; k++) begin
      #2;
      chk($sformatf("post_rst_rv[%0d]", k), 32'(rsp_valid), 32'h0);
      @(negedge clk);
    end
    drive(3'b111, 0, 0, 3'b000);
    #2;
    chk("post_rst_gnt", 32'(gnt), 32'h1);

    @(negedge clk);
    drive(3'b000, 0, 0, 3'b000);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
